// File: rtl/line_delay_ctrl_if.sv
// line_delay_ctrl_if: raw pixel stream in, block-RAM port pair, and the
// vertically paired pixel stream out of the line-delay controller.
interface line_delay_ctrl_if #(parameter int DW = 16, parameter int AW = 12);
  logic in_sof, in_valid, in_eol;
  logic [DW-1:0] in_data;
  logic [AW-1:0] ram_ada, ram_adb;
  logic [DW-1:0] ram_din, ram_dout;
  logic ram_cea, ram_ceb, ram_oce;
  logic out_valid, out_prev_ok, out_eol, overflow;
  logic [DW-1:0] out_cur, out_prev;
  logic [AW-1:0] out_col;
  modport master (
    output in_sof, in_valid, in_eol, in_data, ram_dout,
    input ram_ada, ram_din, ram_cea, ram_adb, ram_ceb, ram_oce,
    input out_valid, out_cur, out_prev, out_prev_ok, out_eol, out_col, overflow
  );
  modport slave (
    input in_sof, in_valid, in_eol, in_data, ram_dout,
    output ram_ada, ram_din, ram_cea, ram_adb, ram_ceb, ram_oce,
    output out_valid, out_cur, out_prev, out_prev_ok, out_eol, out_col, overflow
  );
endinterface

// File: rtl/line_delay_ctrl.sv
// line_delay_ctrl: drives a simple dual-port RAM as a one-line delay and
// pairs every pixel with the stored pixel of the previous line, 2 clk latency.
module line_delay_ctrl #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input logic clk,
  input logic reset,
  line_delay_ctrl_if.slave bus
);
  localparam logic [AW-1:0] COL_MAX = '1;
  logic [AW-1:0] col_q, col_d, s1_col_q, s1_col_d, out_col_q, out_col_d, col_eff;
  logic [AW:0] prev_len_q, prev_len_d;
  logic first_line_q, first_line_d, overflow_q, overflow_d, acc, first_eff;
  logic s1_valid_q, s1_valid_d, s1_eol_q, s1_eol_d, s1_ok_q, s1_ok_d;
  logic out_valid_q, out_valid_d, out_ok_q, out_ok_d, out_eol_q, out_eol_d;
  logic [DW-1:0] s1_data_q, s1_data_d, out_cur_q, out_cur_d, out_prev_q, out_prev_d;
  always_comb begin
    acc = bus.in_valid && !reset;
    col_eff = bus.in_sof ? '0 : col_q;
    first_eff = bus.in_sof || first_line_q;
    col_d = col_q;
    prev_len_d = prev_len_q;
    first_line_d = first_line_q;
    overflow_d = overflow_q;
    if (acc) begin
      col_d = bus.in_eol ? '0 : (col_eff == COL_MAX ? COL_MAX : col_eff + AW'(1));
      prev_len_d = bus.in_eol ? (AW+1)'(col_eff) + (AW+1)'(1) : (bus.in_sof ? '0 : prev_len_q);
      first_line_d = first_eff && !bus.in_eol;
      overflow_d = overflow_q || (!bus.in_eol && col_eff == COL_MAX);
    end
    s1_valid_d = acc;
    s1_data_d = bus.in_data;
    s1_eol_d = bus.in_eol;
    s1_col_d = col_eff;
    s1_ok_d = !first_eff && ((AW+1)'(col_eff) < prev_len_q);
    // ram_dout now holds the word read in the stage-0 cycle of the s1 pixel
    out_valid_d = s1_valid_q;
    out_cur_d = s1_data_q;
    out_prev_d = s1_ok_q ? bus.ram_dout : '0;
    out_ok_d = s1_ok_q;
    out_eol_d = s1_eol_q;
    out_col_d = s1_col_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      prev_len_q <= '0;
      first_line_q <= 1'b1;
      overflow_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_data_q <= '0;
      s1_eol_q <= 1'b0;
      s1_col_q <= '0;
      s1_ok_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_cur_q <= '0;
      out_prev_q <= '0;
      out_ok_q <= 1'b0;
      out_eol_q <= 1'b0;
      out_col_q <= '0;
    end else begin
      col_q <= col_d;
      prev_len_q <= prev_len_d;
      first_line_q <= first_line_d;
      overflow_q <= overflow_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q <= s1_data_d;
      s1_eol_q <= s1_eol_d;
      s1_col_q <= s1_col_d;
      s1_ok_q <= s1_ok_d;
      out_valid_q <= out_valid_d;
      out_cur_q <= out_cur_d;
      out_prev_q <= out_prev_d;
      out_ok_q <= out_ok_d;
      out_eol_q <= out_eol_d;
      out_col_q <= out_col_d;
    end
  end
  // the write trails the read of the same column by one cycle
  assign bus.ram_adb = col_eff;
  assign bus.ram_ceb = acc;
  assign bus.ram_ada = s1_col_q;
  assign bus.ram_din = s1_data_q;
  assign bus.ram_cea = s1_valid_q;
  assign bus.ram_oce = 1'b1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_cur = out_cur_q;
  assign bus.out_prev = out_prev_q;
  assign bus.out_prev_ok = out_ok_q;
  assign bus.out_eol = out_eol_q;
  assign bus.out_col = out_col_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_line_delay_ctrl.sv
// tb_line_delay_ctrl: randomized line streams against a queue-based model of
// the line delay, with a behavioural RAM attached to the controller's ports.
module tb_line_delay_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int LMAX = 1 << AW;
  typedef struct packed {logic v; logic [DW-1:0] cur, prev; logic ok, eol; logic [AW-1:0] col;} out_t;
  typedef struct packed {logic v, sof, eol; logic [DW-1:0] d;} beat_t;
  logic clk = 1'b0;
  logic reset;
  line_delay_ctrl_if #(.DW(DW), .AW(AW)) bus();
  line_delay_ctrl #(.DW(DW), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [DW-1:0] ram [LMAX];
  always @(posedge clk) begin
    if (bus.ram_ceb) bus.ram_dout <= ram[bus.ram_adb];
    if (bus.ram_cea) ram[bus.ram_ada] <= bus.ram_din;
  end
  int vecs = 0, errs = 0;
  bit m_ovf, coll;
  logic [DW-1:0] cur_line[$], prev_line[$];
  out_t pipe[2];
  beat_t stim[$];
  logic [2*AW+DW+1:0] ram_obs, ram_exp;
  function automatic out_t obs_out();
    obs_out = '0;
    if (bus.out_valid) obs_out = '{1'b1, bus.out_cur, bus.out_prev, bus.out_prev_ok, bus.out_eol, bus.out_col};
  endfunction
  function automatic logic [3*DW+3*AW+5:0] all_outs();
    all_outs = {bus.out_valid, bus.out_cur, bus.out_prev, bus.out_prev_ok, bus.out_eol, bus.out_col,
                bus.overflow, bus.ram_cea, bus.ram_ceb, bus.ram_ada, bus.ram_adb, bus.ram_din};
  endfunction
  task automatic add_line(input int len, input bit sof, input int gap_mode, input int base);
    for (int c = 0; c < len; c++) begin
      if (gap_mode == 2 && $urandom_range(0, 2) == 0) stim.push_back('0);
      stim.push_back('{1'b1, sof && c == 0, c == len - 1, base < 0 ? DW'($urandom) : DW'(base + c)});
      if (gap_mode == 1) stim.push_back('0);
    end
  endtask
  task automatic add_gaps(input int n);
    for (int i = 0; i < n; i++) stim.push_back('0);
  endtask
  // One clock: model the pixel (line queues), sample RAM ports mid-cycle, shift expected pipe.
  task automatic cyc(input beat_t b);
    out_t e;
    int c;
    bus.in_valid = b.v; bus.in_sof = b.sof; bus.in_eol = b.eol; bus.in_data = b.d;
    e = '0;
    if (b.v) begin
      if (b.sof) begin cur_line.delete(); prev_line.delete(); end
      c = cur_line.size() < LMAX ? cur_line.size() : LMAX - 1;
      e.v = 1'b1; e.cur = b.d; e.col = AW'(c); e.eol = b.eol;
      e.ok = c < prev_line.size();
      e.prev = e.ok ? prev_line[c] : '0;
      if (cur_line.size() < LMAX) cur_line.push_back(b.d); else cur_line[LMAX-1] = b.d;
      if (cur_line.size() == LMAX && !b.eol) m_ovf = 1'b1;
      if (b.eol) begin prev_line = cur_line; cur_line.delete(); end
    end
    #1;
    ram_obs = {bus.ram_ceb, bus.ram_ceb ? bus.ram_adb : AW'(0), bus.ram_cea,
               bus.ram_cea ? bus.ram_ada : AW'(0), bus.ram_cea ? bus.ram_din : DW'(0)};
    ram_exp = {e.v, e.col, pipe[0].v, pipe[0].col, pipe[0].cur};
    coll = bus.ram_cea && bus.ram_ceb && bus.ram_ada == bus.ram_adb;
    @(posedge clk); #1;
    pipe[1] = pipe[0];
    pipe[0] = e;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1; bus.in_sof = 1'b0; bus.in_eol = 1'b0; bus.in_data = '1;
    pipe[0] = '0; pipe[1] = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (all_outs() !== '0) begin errs++; $display("FAIL reset outs: got %h want 0", all_outs()); end
    vecs++; if (bus.ram_oce !== 1'b1) begin errs++; $display("FAIL reset oce: got %b want 1", bus.ram_oce); end
    reset = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_pairing(input int gap_mode);
    stim.delete();
    add_line(8, 1'b1, gap_mode, 'h100);
    add_line(8, 1'b0, gap_mode, 'h200);
    add_gaps(2);
    foreach (stim[i]) begin
      cyc(stim[i]);
      vecs++; if (obs_out() !== pipe[1]) begin errs++; $display("FAIL pairing%0d out beat %0d: got %h want %h", gap_mode, i, obs_out(), pipe[1]); end
      vecs++; if (ram_obs !== ram_exp) begin errs++; $display("FAIL pairing%0d ram beat %0d: got %h want %h", gap_mode, i, ram_obs, ram_exp); end
      vecs++; if (coll) begin errs++; $display("FAIL pairing%0d collision beat %0d: got ada=adb=%0d want distinct", gap_mode, i, bus.ram_ada); end
    end
  endtask
  task automatic test_short_long();
    stim.delete();
    add_line(10, 1'b1, 2, -1);
    add_line(12, 1'b0, 2, -1);
    add_line(4, 1'b0, 2, -1);
    add_gaps(2);
    foreach (stim[i]) begin
      cyc(stim[i]);
      vecs++; if (obs_out() !== pipe[1]) begin errs++; $display("FAIL short_long out beat %0d: got %h want %h", i, obs_out(), pipe[1]); end
      vecs++; if (ram_obs !== ram_exp) begin errs++; $display("FAIL short_long ram beat %0d: got %h want %h", i, ram_obs, ram_exp); end
    end
  endtask
  task automatic test_sof();
    stim.delete();
    for (int l = 0; l < 3; l++) add_line($urandom_range(4, 12), 1'b0, 2, -1);
    add_line(6, 1'b1, 2, -1);
    add_line(7, 1'b0, 2, -1);
    add_gaps(2);
    foreach (stim[i]) begin
      cyc(stim[i]);
      vecs++; if (obs_out() !== pipe[1]) begin errs++; $display("FAIL sof out beat %0d: got %h want %h", i, obs_out(), pipe[1]); end
      vecs++; if (ram_obs !== ram_exp) begin errs++; $display("FAIL sof ram beat %0d: got %h want %h", i, ram_obs, ram_exp); end
    end
  endtask
  task automatic test_sof_eol();
    stim.delete();
    add_gaps(1);
    add_line(1, 1'b1, 0, -1);
    add_gaps(1);
    add_line(3, 1'b0, 0, -1);
    add_gaps(2);
    foreach (stim[i]) begin
      cyc(stim[i]);
      vecs++; if (obs_out() !== pipe[1]) begin errs++; $display("FAIL sof_eol out beat %0d: got %h want %h", i, obs_out(), pipe[1]); end
    end
  endtask
  task automatic test_overflow();
    stim.delete();
    add_gaps(1);
    add_line(20, 1'b1, 0, -1);
    add_line(16, 1'b0, 2, -1);
    add_gaps(2);
    foreach (stim[i]) begin
      cyc(stim[i]);
      vecs++; if (obs_out() !== pipe[1]) begin errs++; $display("FAIL overflow out beat %0d: got %h want %h", i, obs_out(), pipe[1]); end
      vecs++; if (bus.overflow !== m_ovf) begin errs++; $display("FAIL overflow flag beat %0d: got %b want %b", i, bus.overflow, m_ovf); end
    end
    vecs++; if (bus.overflow !== 1'b1) begin errs++; $display("FAIL overflow sticky: got %b want 1", bus.overflow); end
  endtask
  task automatic test_reset_mid();
    stim.delete();
    add_line(8, 1'b1, 0, -1);
    for (int c = 0; c < 5; c++) stim.push_back('{1'b1, 1'b0, 1'b0, DW'($urandom)});
    foreach (stim[i]) begin
      cyc(stim[i]);
      vecs++; if (obs_out() !== pipe[1]) begin errs++; $display("FAIL reset_mid pre beat %0d: got %h want %h", i, obs_out(), pipe[1]); end
    end
    #1 reset = 1'b1;
    #1;
    vecs++; if (all_outs() !== '0) begin errs++; $display("FAIL reset_mid flush: got %h want 0", all_outs()); end
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    pipe[0] = '0; pipe[1] = '0; m_ovf = 1'b0;
    cur_line.delete(); prev_line.delete();
    stim.delete();
    add_line(6, 1'b0, 2, -1);
    add_gaps(2);
    foreach (stim[i]) begin
      cyc(stim[i]);
      vecs++; if (obs_out() !== pipe[1]) begin errs++; $display("FAIL reset_mid post beat %0d: got %h want %h", i, obs_out(), pipe[1]); end
    end
  endtask
  initial begin
    test_reset();
    test_pairing(0);
    test_pairing(1);
    test_short_long();
    test_sof();
    test_sof_eol();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
